// File: rtl/collision_scheduler_if.sv
// Sprite attribute RAM read port: the scheduler issues strobe/address,
// the RAM returns entry fields one cycle later.
interface collision_scheduler_if #(
    parameter int IDX_W   = 4,
    parameter int COORD_W = 10
) ();
    logic               spr_rd_en;
    logic [IDX_W-1:0]   spr_addr;
    logic               spr_valid;
    logic [COORD_W-1:0] spr_x;
    logic [COORD_W-1:0] spr_y;
    logic [COORD_W-1:0] spr_w;
    logic [COORD_W-1:0] spr_h;

    modport master (
        output spr_rd_en, spr_addr,
        input  spr_valid, spr_x, spr_y, spr_w, spr_h
    );

    modport slave (
        input  spr_rd_en, spr_addr,
        output spr_valid, spr_x, spr_y, spr_w, spr_h
    );
endinterface

// File: rtl/collision_scheduler.sv
// Per-frame collision scheduler: walks the sprite RAM once per frame_start
// and produces registered contact flags for the 16x16 player box.
module collision_scheduler #(
    parameter int NUM_SPRITES = 16,
    parameter int IDX_W       = 4,
    parameter int COORD_W     = 10,
    parameter int PLAYER_S    = 16,
    parameter int MARGIN      = 3,
    parameter int FLOOR_Y     = 396
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_start,
    input  logic [COORD_W-1:0]  PlayerX,
    input  logic [COORD_W-1:0]  PlayerY,
    collision_scheduler_if.master spr,
    output logic                busy,
    output logic                done,
    output logic                block_left,
    output logic                block_right,
    output logic                block_up,
    output logic                block_down,
    output logic [IDX_W-1:0]    ground_idx,
    output logic                ground_hit,
    output logic                overrun
);

    // One extra bit so every sum is exact (no wrap at the screen edge).
    localparam int W1 = COORD_W + 1;
    localparam logic [W1-1:0]    PS_E     = W1'(PLAYER_S);
    localparam logic [W1-1:0]    MARGIN_E = W1'(MARGIN);
    localparam logic [W1-1:0]    FLOOR_E  = W1'(FLOOR_Y);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic               acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic               acc_u_q, acc_u_d, acc_d_q, acc_d_d;
    logic               acc_hit_q, acc_hit_d;
    logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
    logic               blk_l_q, blk_l_d, blk_r_q, blk_r_d;
    logic               blk_u_q, blk_u_d, blk_d_q, blk_d_d;
    logic               ghit_q, ghit_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic               busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

    logic [W1-1:0] px_e, py_e, sx_e, sy_e;
    logic [W1-1:0] sx_w, sy_h, px_s, py_s, px_m, py_m, sx_m, sy_m;
    logic          entry_ok, hov, vov, hit_l, hit_r, hit_u, hit_d, on_floor;

    // State register and all datapath flops.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            px_q      <= '0;
            py_q      <= '0;
            cmp_vld_q <= 1'b0;
            cmp_idx_q <= '0;
            acc_l_q   <= 1'b0;
            acc_r_q   <= 1'b0;
            acc_u_q   <= 1'b0;
            acc_d_q   <= 1'b0;
            acc_hit_q <= 1'b0;
            acc_idx_q <= '0;
            blk_l_q   <= 1'b0;
            blk_r_q   <= 1'b0;
            blk_u_q   <= 1'b0;
            blk_d_q   <= 1'b0;
            ghit_q    <= 1'b0;
            gidx_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            px_q      <= px_d;
            py_q      <= py_d;
            cmp_vld_q <= cmp_vld_d;
            cmp_idx_q <= cmp_idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            acc_u_q   <= acc_u_d;
            acc_d_q   <= acc_d_d;
            acc_hit_q <= acc_hit_d;
            acc_idx_q <= acc_idx_d;
            blk_l_q   <= blk_l_d;
            blk_r_q   <= blk_r_d;
            blk_u_q   <= blk_u_d;
            blk_d_q   <= blk_d_d;
            ghit_q    <= ghit_d;
            gidx_q    <= gidx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state: one address per SCAN cycle, one DRAIN cycle for the last read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: RAM read strobe and address.
    always_comb begin
        spr.spr_rd_en = (state_q == SCAN);
        spr.spr_addr  = idx_q;
    end

    // Per-entry contact tests against the entry returned this cycle.
    always_comb begin
        px_e = {1'b0, px_q};
        py_e = {1'b0, py_q};
        sx_e = {1'b0, spr.spr_x};
        sy_e = {1'b0, spr.spr_y};
        sx_w = sx_e + {1'b0, spr.spr_w};
        sy_h = sy_e + {1'b0, spr.spr_h};
        px_s = px_e + PS_E;
        py_s = py_e + PS_E;
        px_m = px_e + MARGIN_E;
        py_m = py_e + MARGIN_E;
        sx_m = sx_e + MARGIN_E;
        sy_m = sy_e + MARGIN_E;
        entry_ok = cmp_vld_q && spr.spr_valid && (spr.spr_w != '0) && (spr.spr_h != '0);
        hov   = (px_e < sx_w) && (sx_e < px_s);
        vov   = (py_e < sy_h) && (sy_e < py_s);
        hit_d = entry_ok && hov && (sy_e <= py_s) && (py_s <= sy_m);
        hit_u = entry_ok && hov && (py_m >= sy_h) && (py_e <= sy_h);
        hit_r = entry_ok && vov && (sx_e <= px_s) && (px_s <= sx_m);
        hit_l = entry_ok && vov && (px_m >= sx_w) && (px_e <= sx_w);
        on_floor = (py_s >= FLOOR_E);
    end

    // Scan bookkeeping, accumulation and the end-of-scan result update.
    always_comb begin
        idx_d     = idx_q;
        px_d      = px_q;
        py_d      = py_q;
        cmp_vld_d = (state_q == SCAN);
        cmp_idx_d = idx_q;
        acc_l_d   = acc_l_q | hit_l;
        acc_r_d   = acc_r_q | hit_r;
        acc_u_d   = acc_u_q | hit_u;
        acc_d_d   = acc_d_q | hit_d;
        acc_hit_d = acc_hit_q | hit_d;
        acc_idx_d = (hit_d && !acc_hit_q) ? cmp_idx_q : acc_idx_q;
        blk_l_d   = blk_l_q;
        blk_r_d   = blk_r_q;
        blk_u_d   = blk_u_q;
        blk_d_d   = blk_d_q;
        ghit_d    = ghit_q;
        gidx_d    = gidx_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == DRAIN);
        ovr_d     = ovr_q | (frame_start && (state_q != IDLE));

        if (state_q == SCAN) idx_d = idx_q + IDX_W'(1);

        if (state_q == IDLE) begin
            idx_d = '0;
            if (frame_start) begin
                px_d      = PlayerX;
                py_d      = PlayerY;
                acc_l_d   = 1'b0;
                acc_r_d   = 1'b0;
                acc_u_d   = 1'b0;
                acc_d_d   = 1'b0;
                acc_hit_d = 1'b0;
                acc_idx_d = '0;
            end
        end

        // Load on the DRAIN edge so the flags and done appear together in DONE.
        if (state_q == DRAIN) begin
            blk_l_d = acc_l_d;
            blk_r_d = acc_r_d;
            blk_u_d = acc_u_d;
            blk_d_d = acc_d_d | on_floor;
            ghit_d  = acc_hit_d;
            gidx_d  = acc_idx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign block_left  = blk_l_q;
    assign block_right = blk_r_q;
    assign block_up    = blk_u_q;
    assign block_down  = blk_d_q;
    assign ground_hit  = ghit_q;
    assign ground_idx  = gidx_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a 1-cycle-latency sprite RAM model.
module tb_collision_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic [9:0] PlayerX, PlayerY;
    logic       busy, done, block_left, block_right, block_up, block_down;
    logic [3:0] ground_idx;
    logic       ground_hit, overrun;

    int checks = 0;
    int errors = 0;
    int done_cyc, rd_cycles, addr_bad, late_done;

    logic       m_v [16];
    logic [9:0] m_x [16];
    logic [9:0] m_y [16];
    logic [9:0] m_w [16];
    logic [9:0] m_h [16];

    collision_scheduler_if #(.IDX_W(4), .COORD_W(10)) sif ();

    collision_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .spr(sif),
        .busy(busy), .done(done),
        .block_left(block_left), .block_right(block_right),
        .block_up(block_up), .block_down(block_down),
        .ground_idx(ground_idx), .ground_hit(ground_hit), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (sif.spr_rd_en) begin
            sif.spr_valid <= m_v[sif.spr_addr];
            sif.spr_x     <= m_x[sif.spr_addr];
            sif.spr_y     <= m_y[sif.spr_addr];
            sif.spr_w     <= m_w[sif.spr_addr];
            sif.spr_h     <= m_h[sif.spr_addr];
        end
    end

    function automatic logic [3:0] flags();
        return {block_left, block_right, block_up, block_down};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sprites();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; m_w[i] = '0; m_h[i] = '0;
        end
    endtask

    task automatic set_spr(input int i, input logic v, input int x, input int y, input int w, input int h);
        m_v[i] = v; m_x[i] = 10'(x); m_y[i] = 10'(y); m_w[i] = 10'(w); m_h[i] = 10'(h);
    endtask

    // Pulse frame_start in cycle 0, then observe cycles 1.. until done (bounded).
    // fs2: cycle of an extra frame_start; chg: cycle at which the player inputs move.
    task automatic scan(input int px, input int py, input int fs2, input int chg);
        PlayerX = 10'(px); PlayerY = 10'(py);
        @(negedge Clk); frame_start = 1'b1;
        @(negedge Clk); frame_start = 1'b0;
        done_cyc = -1; rd_cycles = 0; addr_bad = 0;
        for (int c = 1; c < 40 && done_cyc < 0; c++) begin
            frame_start = (c == fs2);
            if (c == chg) begin PlayerX = 10'd84; PlayerY = 10'd300; end
            if (sif.spr_rd_en) begin
                if (sif.spr_addr !== 4'(rd_cycles)) addr_bad++;
                rd_cycles++;
            end
            if (done) done_cyc = c;
            @(negedge Clk);
        end
        frame_start = 1'b0;
    endtask

    task automatic check_scan(input string tag, input logic [3:0] ef, input logic eh, input logic [3:0] ei);
        chk({tag, "_done_cycle"}, done_cyc, 18);
        chk({tag, "_flags"}, flags(), ef);
        chk({tag, "_ground_hit"}, ground_hit, eh);
        chk({tag, "_ground_idx"}, ground_idx, ei);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        Reset = 1'b0; frame_start = 1'b0; PlayerX = '0; PlayerY = '0;
        clear_sprites();
        repeat (3) @(negedge Clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", flags(), 4'b0000);
        chk("rst_gidx", ground_idx, 4'd0);
        chk("rst_ghit", ground_hit, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_rd_en", sif.spr_rd_en, 1'b0);
        Reset = 1'b1;
        @(negedge Clk);

        // Single sprite at idx 0, standing on top of it.
        set_spr(0, 1'b1, 100, 300, 32, 16);
        scan(108, 284, -1, -1);
        check_scan("top", 4'b0001, 1'b1, 4'd0);
        chk("top_rd_cycles", rd_cycles, 16);
        chk("top_addr_seq_bad", addr_bad, 0);

        scan(84, 300, -1, -1);
        check_scan("right", 4'b0100, 1'b0, 4'd0);
        scan(132, 300, -1, -1);
        check_scan("left", 4'b1000, 1'b0, 4'd0);
        scan(108, 316, -1, -1);
        check_scan("up", 4'b0010, 1'b0, 4'd0);

        // Two down contacts: the lower index wins.
        clear_sprites();
        set_spr(5, 1'b1, 100, 300, 32, 16);
        set_spr(9, 1'b1, 50, 300, 100, 8);
        scan(108, 284, -1, -1);
        check_scan("gidx", 4'b0001, 1'b1, 4'd5);

        // Floor only.
        clear_sprites();
        scan(200, 380, -1, -1);
        check_scan("floor", 4'b0001, 1'b0, 4'd0);
        scan(200, 379, -1, -1);
        check_scan("above_floor", 4'b0000, 1'b0, 4'd0);

        // Penetration depth limits.
        set_spr(0, 1'b1, 100, 300, 32, 16);
        scan(108, 287, -1, -1);
        check_scan("pen3", 4'b0001, 1'b1, 4'd0);
        scan(108, 288, -1, -1);
        check_scan("pen4", 4'b0000, 1'b0, 4'd0);

        // Disabled and zero-size entries are ignored.
        clear_sprites();
        set_spr(0, 1'b0, 100, 290, 32, 32);
        set_spr(2, 1'b1, 100, 300, 32, 0);
        scan(108, 300, -1, -1);
        check_scan("invalid", 4'b0000, 1'b0, 4'd0);
        scan(108, 284, -1, -1);
        check_scan("zero_h", 4'b0000, 1'b0, 4'd0);

        // Extra frame_start mid-scan plus player movement: both ignored.
        clear_sprites();
        set_spr(0, 1'b1, 100, 300, 32, 16);
        chk("pre_overrun", overrun, 1'b0);
        scan(108, 284, 5, 3);
        check_scan("overrun", 4'b0001, 1'b1, 4'd0);
        chk("overrun_flag", overrun, 1'b1);

        // Reset at cycle 10 of a scan: everything clears, no done afterwards.
        PlayerX = 10'd84; PlayerY = 10'd300;
        @(negedge Clk); frame_start = 1'b1;
        @(negedge Clk); frame_start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_flags", flags(), 4'b0000);
        chk("midrst_ghit", ground_hit, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_rd_en", sif.spr_rd_en, 1'b0);
        @(negedge Clk); Reset = 1'b1;
        late_done = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) late_done++;
            @(negedge Clk);
        end
        chk("midrst_no_done", late_done, 0);
        scan(84, 300, -1, -1);
        check_scan("after_rst", 4'b0100, 1'b0, 4'd0);
        chk("after_rst_rd_cycles", rd_cycles, 16);
        chk("after_rst_overrun", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
